riscv_fetch_queue: RTL
======================

# riscv_fetch_queue

Parametrised instruction-fetch front end with a decoupling queue between the IF and ID stages. Generates sequential PCs, issues requests to a one-cycle-latency instruction memory, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and hands them to ID over a valid/ready handshake. A branch redirect flushes the queue and any in-flight fetch. It replaces the fixed single-register IF/ID handoff with configurable buffering and stall-tolerant prefetch.

## Interface
- XLEN, 32, PC/address width.
- DEPTH, 4, queue entries; power of two, ≥ 2.
- RESET_PC, 0, fetch address after reset.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- PCSrc  in  1  redirect request; highest priority.
- PC_Branch  in  XLEN  redirect target, sampled when PCSrc=1.
- ID_ready  in  1  ID accepts head entry this cycle.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  fetch address (= pc_f).
- imem_rdata  in  32  instruction for the previous cycle's request.
- ID_valid  out  1  head entry valid.
- PC_ID  out  XLEN  PC of head entry.
- INSTRUCTION_ID  out  32  instruction of head entry.
- count  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- State: pc_f, inflight flag, inflight_pc, circular queue (wr_ptr, rd_ptr, count).
- pop = ID_valid & ID_ready.
- imem_req = reset & ~PCSrc & ((count + inflight < DEPTH) | pop). Issue ⇒ pc_f += 4, modulo 2^XLEN; inflight <= 1, inflight_pc <= pc_f. No issue ⇒ inflight <= 0.
- Response: when inflight=1, imem_rdata is valid this cycle; push {inflight_pc, imem_rdata} to the queue.
- Push and pop in the same cycle leave count unchanged. The credit rule guarantees the queue never overflows. Pointers wrap modulo DEPTH.
- Redirect (PCSrc=1): pc_f <= PC_Branch; count, wr_ptr, rd_ptr <= 0; inflight <= 0. Any response arriving this cycle is discarded. No pop occurs: ID_valid is forced 0 this cycle regardless of ID_ready. imem_req=0.
- Head outputs: ID_valid = (count≠0) & ~PCSrc. PC_ID and INSTRUCTION_ID show the head entry when ID_valid=1, else 0.
- Reset (any time, including mid-fetch or full queue): pc_f=RESET_PC; count, pointers, inflight = 0. All outputs 0, except imem_addr=RESET_PC.

## Timing
- Request in cycle N → data captured at the end of N+1 → ID_valid in N+2 (2-cycle fetch-to-ID latency; 1 cycle with bypass).
- Sustained throughput is one instruction per cycle while ID_ready=1, for DEPTH ≥ 2.
- First imem_req is in the first cycle with reset high. imem_addr=RESET_PC.
- Redirect in cycle R: first request to PC_Branch is in R+1. First ID_valid is in R+3, or R+2 with bypass.
- ID_ready low for k cycles: the queue fills to DEPTH, then imem_req drops and pc_f holds.
- Response ordering is strictly in program order; no reordering.

## Configuration
- FETCH_BYPASS_EN defined: when count=0, inflight=1, and PCSrc=0, ID_valid=1 that cycle with PC_ID=inflight_pc and INSTRUCTION_ID=imem_rdata (combinational from imem_rdata).
  - If ID_ready=1, the entry is consumed and not pushed.
  - If ID_ready=0, it is pushed normally.
- Undefined: every response passes through the queue. Outputs depend only on registered state and PCSrc.

## Test plan
- Reset low for 2 cycles, then high, ID_ready=1, memory returns 0x00000013+addr: imem_addr = 0,4,8,…. ID_valid rises 2 cycles after the first req (1 with bypass). PC_ID = 0,4,8 on consecutive cycles with no bubbles.
- ID_ready=0 for 10 cycles after startup, DEPTH=4: count reaches 4. imem_req stays 0 once count+inflight=4. pc_f holds at 0x10. Releasing ID_ready drains PC_ID = 0,4,8,0xC, then 0x10 without gaps.
- PCSrc=1 for one cycle, PC_Branch=0x200, with 3 entries queued and one in flight: next cycle count=0 and ID_valid=0. Next PC_ID seen is 0x200. No stale PCs (0x0–0x14) appear afterwards.
- PCSrc asserted in the same cycle as a response and ID_ready=1: response dropped, no pop, count=0 next cycle.
- XLEN=32, RESET_PC=0xFFFFFFF8: fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap), and PC_ID follows the same order.
- reset dropped with the queue full and a request in flight: all outputs 0 immediately (asynchronous). After release, fetch restarts at RESET_PC with count=0.

Source files
------------

// File: rtl/riscv_fetch_queue.sv
// rtl/riscv_fetch_queue.sv - IF stage with prefetch queue feeding ID over valid/ready.
// Optional FETCH_BYPASS_EN: a response may go straight to ID when the queue is empty.
module riscv_fetch_queue #(
    parameter int XLEN                  = 32,
    parameter int DEPTH                 = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     PCSrc,
    input  logic [XLEN-1:0]          PC_Branch,
    input  logic                     ID_ready,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     ID_valid,
    output logic [XLEN-1:0]          PC_ID,
    output logic [31:0]              INSTRUCTION_ID,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];

    logic            bypass;
    logic            pop;
    logic            queue_pop;
    logic            push;
    logic [CW-1:0]   occupancy;

`ifdef FETCH_BYPASS_EN
    assign bypass = (count == '0) && inflight && !PCSrc;
`else
    assign bypass = 1'b0;
`endif

    assign ID_valid       = ((count != '0) || bypass) && !PCSrc;
    assign PC_ID          = !ID_valid ? '0 : (bypass ? inflight_pc : q_pc[rd_ptr]);
    assign INSTRUCTION_ID = !ID_valid ? '0 : (bypass ? imem_rdata : q_instr[rd_ptr]);
    assign pop            = ID_valid && ID_ready;
    assign queue_pop      = pop && !bypass;
    // A bypassed response that ID takes this cycle never occupies a slot.
    assign push           = inflight && !PCSrc && !(bypass && ID_ready);

    // Credit counts the in-flight fetch so a full queue can never be overrun.
    assign occupancy = count + CW'(inflight);
    assign imem_req  = reset && !PCSrc && ((occupancy < CW'(DEPTH)) || pop);
    assign imem_addr = pc_f;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (PCSrc) begin
            pc_f     <= PC_Branch;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc_f        <= pc_f + XLEN'(4);
                inflight_pc <= pc_f;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (queue_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !queue_pop) begin
                count <= count + CW'(1);
            end else if (queue_pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= inflight_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end
endmodule
